// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access-size funct3 codes, FSM states, legality helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsuState_t;

    // Size/alignment legality of a request; stores have no unsigned variants.
    function automatic logic isLegal(input logic [2:0] f3, input logic [1:0] addrLo,
                                     input logic isStore);
        logic ok;
        case (f3)
            F3_B, F3_BU: ok = 1'b1;
            F3_H, F3_HU: ok = ~addrLo[0];
            F3_W:        ok = (addrLo == 2'b00);
            default:     ok = 1'b0;
        endcase
        if (isStore && f3[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Latency: none (wires only).
// Backpressure: master holds request fields stable until bus_ack.
interface lsu_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data replication, load lane extraction and extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  reqFunct3,
    input  logic [1:0]  reqAddrLo,
    input  logic [31:0] reqWdata,
    output logic [3:0]  byteEn,
    output logic [31:0] wdataRep,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldAddrLo,
    input  logic [31:0] ldRaw,
    output logic [31:0] ldData
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Store side: enables shifted into the addressed lane, data copied into every lane.
    always_comb begin
        byteEn   = 4'b1111;
        wdataRep = reqWdata;
        case (reqFunct3)
            F3_B, F3_BU: begin
                byteEn   = 4'b0001 << reqAddrLo;
                wdataRep = {4{reqWdata[7:0]}};
            end
            F3_H, F3_HU: begin
                byteEn   = 4'b0011 << reqAddrLo;
                wdataRep = {2{reqWdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend by access type.
    always_comb begin
        case (ldAddrLo)
            2'd0:    laneByte = ldRaw[7:0];
            2'd1:    laneByte = ldRaw[15:8];
            2'd2:    laneByte = ldRaw[23:16];
            default: laneByte = ldRaw[31:24];
        endcase
        laneHalf = ldAddrLo[1] ? ldRaw[31:16] : ldRaw[15:0];
        case (ldFunct3)
            F3_B:    ldData = {{24{laneByte[7]}}, laneByte};
            F3_BU:   ldData = {24'd0, laneByte};
            F3_H:    ldData = {{16{laneHalf[15]}}, laneHalf};
            F3_HU:   ldData = {16'd0, laneHalf};
            default: ldData = ldRaw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: single-outstanding data-bus access with stall, alignment checks and timeout.
// Latency: legal access done 2 cycles after request; illegal access done next cycle.
// Backpressure: stalls the core until done; bus fields held stable until bus_ack or timeout.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    lsu_ctrl_if.master  busIf
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsuState_t   state, nextState;
    logic [7:0]  waitCnt;
    logic [2:0]  reqFunct3;
    logic [1:0]  reqAddrLo;
    logic        busReq, busWe;
    logic [3:0]  busBe;
    logic [31:0] busAddr, busWdata;
    logic [31:0] rdataReg;
    logic        faultReg;

    logic        reqValid, reqStore, reqLegal, timedOut;
    logic [3:0]  byteEn;
    logic [31:0] wdataRep, ldData;

    assign reqValid = MemRead | MemWrite;
    assign reqStore = MemWrite;
    assign reqLegal = isLegal(funct3, addr[1:0], reqStore);
    assign timedOut = (waitCnt == TIMEOUT_CNT);

    lsu_align uAlign (
        .reqFunct3 (funct3),
        .reqAddrLo (addr[1:0]),
        .reqWdata  (wdata),
        .byteEn    (byteEn),
        .wdataRep  (wdataRep),
        .ldFunct3  (reqFunct3),
        .ldAddrLo  (reqAddrLo),
        .ldRaw     (busIf.bus_rdata),
        .ldData    (ldData)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and stall decode; ack takes priority over the timeout in the same cycle.
    always_comb begin
        nextState = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = reqValid;
                if (reqValid) begin
                    nextState = reqLegal ? REQ : DONE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (busIf.bus_ack || timedOut) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request latching, wait counter and completion capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            busReq    <= 1'b0;
            busWe     <= 1'b0;
            busBe     <= 4'd0;
            busAddr   <= 32'd0;
            busWdata  <= 32'd0;
            reqFunct3 <= 3'd0;
            reqAddrLo <= 2'd0;
            waitCnt   <= 8'd0;
            rdataReg  <= 32'd0;
            faultReg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid && reqLegal) begin
                        busReq    <= 1'b1;
                        busWe     <= reqStore;
                        busBe     <= byteEn;
                        busAddr   <= {addr[31:2], 2'b00};
                        busWdata  <= wdataRep;
                        reqFunct3 <= funct3;
                        reqAddrLo <= addr[1:0];
                        waitCnt   <= 8'd0;
                    end else if (reqValid) begin
                        faultReg <= 1'b1;
                        rdataReg <= 32'd0;
                    end
                end
                REQ: begin
                    if (busIf.bus_ack) begin
                        busReq   <= 1'b0;
                        faultReg <= busIf.bus_err;
                        rdataReg <= (busIf.bus_err || busWe) ? 32'd0 : ldData;
                    end else if (timedOut) begin
                        busReq   <= 1'b0;
                        faultReg <= 1'b1;
                        rdataReg <= 32'd0;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done            = (state == DONE);
    assign fault           = faultReg;
    assign rdata           = rdataReg;
    assign busIf.bus_req   = busReq;
    assign busIf.bus_we    = busWe;
    assign busIf.bus_be    = busBe;
    assign busIf.bus_addr  = busAddr;
    assign busIf.bus_wdata = busWdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized accesses against a size/lane model.
// Latency: n/a.
// Backpressure: bench plays the memory and injects ack delays, errors and timeouts.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    lsu_ctrl_if busIf ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .stall    (stall),
        .rdata    (rdata),
        .done     (done),
        .fault    (fault),
        .busIf    (busIf.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes from the size code.
    function automatic int accSize(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit modelLegal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int lo = int'(a[1:0]);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (wr && f3 > 3'd2) return 0;
        return (lo % accSize(f3)) == 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
        int m = ((1 << accSize(f3)) - 1) << int'(a[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        case (accSize(f3))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] raw);
        int sz = accSize(f3);
        logic [31:0] v = raw >> (8 * int'(a[1:0]));
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = v & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // One access; ackDelay < 0 means memory never answers.
    task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int ackDelay, input logic err, input logic [31:0] raw);
        bit legal = modelLegal(wr, f3, a);
        int stallCnt = 0;
        int reqCycles = 0;
        bit finished = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk("stall_idle", stall, 1'b1);
        if (stall) stallCnt++;
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b0;
        if (!legal) begin
            chk("illegal_done", done, 1'b1);
            chk("illegal_fault", fault, 1'b1);
            chk("illegal_rdata", rdata, 32'd0);
            chk("illegal_noreq", busIf.bus_req, 1'b0);
            chk("illegal_stall", stall, 1'b0);
        end else begin
            while (!finished && reqCycles < 40) begin
                chk("bus_req", busIf.bus_req, 1'b1);
                chk("bus_addr", busIf.bus_addr, {a[31:2], 2'b00});
                if (reqCycles == 0) begin
                    chk("bus_be", busIf.bus_be, modelBe(f3, a));
                    chk("bus_we", busIf.bus_we, wr);
                    if (wr) chk("bus_wdata", busIf.bus_wdata, modelWdata(f3, wd));
                end
                if (stall) stallCnt++;
                if (ackDelay >= 0 && reqCycles == ackDelay) begin
                    busIf.bus_ack = 1'b1; busIf.bus_err = err; busIf.bus_rdata = raw;
                end
                @(negedge clk);
                busIf.bus_ack = 1'b0; busIf.bus_err = 1'b0; busIf.bus_rdata = $urandom;
                reqCycles++;
                if (done) finished = 1;
            end
            chk("done", done, 1'b1);
            chk("done_stall", stall, 1'b0);
            if (ackDelay < 0) begin
                chk("timeout_fault", fault, 1'b1);
                chk("timeout_cycles", reqCycles, TO + 1);
                if (!wr) chk("timeout_rdata", rdata, 32'd0);
            end else begin
                chk("ack_cycles", reqCycles, ackDelay + 1);
                chk("ack_fault", fault, err);
                if (!wr) chk("load_rdata", rdata, err ? 32'd0 : modelLoad(f3, a, raw));
            end
            chk("stall_cycles", stallCnt, reqCycles + 1);
        end
        @(negedge clk);
        chk("back_idle", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        busIf.bus_ack = 1'b0; busIf.bus_err = 1'b0; busIf.bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", busIf.bus_req, 1'b0);
        chk("rst_we", busIf.bus_we, 1'b0);
        chk("rst_be", busIf.bus_be, 4'd0);
        chk("rst_addr", busIf.bus_addr, 32'd0);
        chk("rst_wdata", busIf.bus_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_stall", stall, 1'b0);
        reset = 1'b0;

        // sw 0x104
        doAccess(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 1'b0, 32'd0);
        chk("sw_be_lit", busIf.bus_be, 4'b1111);
        chk("sw_wdata_lit", busIf.bus_wdata, 32'hDEAD_BEEF);
        // lb / lbu / lhu
        doAccess(1'b1, 1'b0, 3'b000, 32'h203, 32'd0, 0, 1'b0, 32'h8011_2233);
        chk("lb_lit", rdata, 32'hFFFF_FF80);
        doAccess(1'b1, 1'b0, 3'b100, 32'h203, 32'd0, 1, 1'b0, 32'h8011_2233);
        chk("lbu_lit", rdata, 32'h0000_0080);
        doAccess(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 2, 1'b0, 32'h8011_2233);
        chk("lhu_lit", rdata, 32'h0000_8011);
        // sh at 0x2
        doAccess(1'b0, 1'b1, 3'b001, 32'h2, 32'h0000_ABCD, 0, 1'b0, 32'd0);
        chk("sh_be_lit", busIf.bus_be, 4'b1100);
        chk("sh_wdata_lit", busIf.bus_wdata, 32'hABCD_ABCD);
        // illegal: misaligned lw, reserved funct3, store with unsigned size, both strobes
        doAccess(1'b1, 1'b0, 3'b010, 32'h6, 32'd0, 0, 1'b0, 32'd0);
        doAccess(1'b1, 1'b0, 3'b011, 32'h8, 32'd0, 0, 1'b0, 32'd0);
        doAccess(1'b1, 1'b1, 3'b100, 32'h8, 32'd0, 0, 1'b0, 32'd0);
        // both strobes legal word: acts as store
        doAccess(1'b1, 1'b1, 3'b010, 32'h40, 32'h1234_5678, 0, 1'b0, 32'd0);
        // timeout and bus error
        doAccess(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, -1, 1'b0, 32'd0);
        doAccess(1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 1, 1'b1, 32'h5555_AAAA);

        // reset in third REQ cycle, then a late ack
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'h100;
        @(negedge clk);
        MemRead = 1'b0;
        chk("rstreq_req1", busIf.bus_req, 1'b1);
        repeat (2) @(negedge clk);
        chk("rstreq_req3", busIf.bus_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstreq_dropped", busIf.bus_req, 1'b0);
        chk("rstreq_nodone", done, 1'b0);
        chk("rstreq_nostall", stall, 1'b0);
        busIf.bus_ack = 1'b1;
        @(negedge clk);
        busIf.bus_ack = 1'b0;
        chk("late_ack_nodone", done, 1'b0);
        @(negedge clk);
        chk("late_ack_nodone2", done, 1'b0);

        // randomized accesses
        for (int i = 0; i < 40; i++) begin
            logic [1:0] strobe = 2'($urandom_range(1, 3));
            logic [2:0] f3 = 3'($urandom);
            logic [31:0] a = $urandom;
            doAccess(strobe[0], strobe[1], f3, a, $urandom, $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
